meas_sequencer: RTL

Measurement-cycle controller for the signal parameter measurement datapath. Sequences fixed-length gate windows, requests and waits for an FFT spectrum frame for THD, then allows a pipeline-settle period. It publishes a result strobe to the display/report logic through a valid/ready handshake. Optional auto-ranging picks the next gate time from the last edge count.

---
 rtl/meas_if.sv | 33 +++
 rtl/meas_sequencer.sv | 80 ++++++++
 2 files changed

// File: rtl/meas_if.sv
// meas_if: control, FFT handshake and result handshake bundle for meas_sequencer.
interface meas_if;
    logic        start;
    logic        stop;
    logic        continuous;
    logic        auto_range;
    logic [1:0]  gate_sel_in;
    logic [31:0] edge_count;
    logic        fft_ack;
    logic        fft_done;
    logic        result_ready;
    logic        gate_en;
    logic        gate_done;
    logic        fft_req;
    logic        thd_en;
    logic        result_valid;
    logic        thd_stale;
    logic [1:0]  gate_sel_out;
    logic        busy;
    logic        timeout_err;
    modport master (
        input  start, stop, continuous, auto_range, gate_sel_in, edge_count,
               fft_ack, fft_done, result_ready,
        output gate_en, gate_done, fft_req, thd_en, result_valid, thd_stale,
               gate_sel_out, busy, timeout_err
    );
    modport slave (
        output start, stop, continuous, auto_range, gate_sel_in, edge_count,
               fft_ack, fft_done, result_ready,
        input  gate_en, gate_done, fft_req, thd_en, result_valid, thd_stale,
               gate_sel_out, busy, timeout_err
    );
endinterface

// File: rtl/meas_sequencer.sv
// meas_sequencer: gate window -> FFT frame -> settle -> publish measurement controller
module meas_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int CALC_LAT    = 8,
    parameter int FFT_TIMEOUT = 2_000_000,
    parameter int RANGE_LO    = 100,
    parameter int RANGE_HI    = 60_000
) (
    input logic    clk,
    input logic    rst,
    meas_if.master bus
);
    typedef enum logic [2:0] {IDLE, GATE, FFT_REQ, FFT_WAIT, CALC, PUBLISH} state_t;
    state_t      state, nxt;
    logic [31:0] cnt, gate_len;
    logic [1:0]  sel, range_sel, range_nxt;
    logic        stale, terr;
    logic        gate_last, wait_last, calc_last, launch, to_fire, calc_exit;
    always_comb begin
        gate_len  = sel == 2'd0 ? 32'(CLK_HZ / 100) :
                    sel == 2'd1 ? 32'(CLK_HZ / 10)  :
                    sel == 2'd2 ? 32'(CLK_HZ)       : 32'(CLK_HZ * 10);
        gate_last = cnt == gate_len - 32'd1;
        wait_last = cnt == 32'(FFT_TIMEOUT - 1);
        calc_last = cnt == 32'(CALC_LAT - 1);
        nxt = state;
        case (state)
            IDLE:     nxt = bus.start ? GATE : IDLE;
            GATE:     nxt = gate_last ? FFT_REQ : GATE;
            FFT_REQ:  nxt = bus.fft_ack ? FFT_WAIT : wait_last ? CALC : FFT_REQ;
            FFT_WAIT: nxt = (bus.fft_done || wait_last) ? CALC : FFT_WAIT;
            CALC:     nxt = calc_last ? PUBLISH : CALC;
            PUBLISH:  nxt = bus.result_ready ? (bus.continuous ? GATE : IDLE) : PUBLISH;
            default:  nxt = IDLE;
        endcase
        if (bus.stop)
            nxt = IDLE;
        launch    = nxt == GATE && state != GATE;
        // a real ack/done in the final wait cycle beats the timeout
        to_fire   = wait_last && !bus.stop &&
                    ((state == FFT_REQ && !bus.fft_ack) || (state == FFT_WAIT && !bus.fft_done));
        calc_exit = state == CALC && calc_last && !bus.stop;
        range_nxt = (bus.edge_count < 32'(RANGE_LO) && range_sel != 2'd3) ? range_sel + 2'd1 :
                    (bus.edge_count > 32'(RANGE_HI) && range_sel != 2'd0) ? range_sel - 2'd1 : range_sel;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            range_sel <= 2'd2;
            stale     <= 1'b0;
            terr      <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 32'd1;
            if (launch) begin
                sel   <= bus.auto_range ? range_sel : bus.gate_sel_in;
                stale <= 1'b0;
            end
            if (launch && state == IDLE)
                terr <= 1'b0;
            if (to_fire) begin
                terr  <= 1'b1;
                stale <= 1'b1;
            end
            if (calc_exit && bus.auto_range)
                range_sel <= range_nxt;
        end
    end
    assign bus.gate_en      = state == GATE;
    assign bus.gate_done    = state == GATE && gate_last;
    assign bus.fft_req      = state == FFT_REQ;
    assign bus.thd_en       = state == FFT_WAIT;
    assign bus.result_valid = state == PUBLISH;
    assign bus.busy         = state != IDLE;
    assign bus.gate_sel_out = sel;
    assign bus.thd_stale    = stale;
    assign bus.timeout_err  = terr;
endmodule
